audio_ns_seq: RTL

//  Sample sequencer in front of one fix_audio_ns engine. Buffers incoming samples in a small FIFO and

---
 rtl/audio_ns_seq_if.sv | 43 ++++
 rtl/audio_ns_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/audio_ns_seq_if.sv
// Sample-in, result-out and engine toggle-handshake bundle for audio_ns_seq.
// slave: sequencer side. master: source/sink/engine side.
//   in_*  : sample stream into the sequencer (valid/ready)
//   out_* : result stream out of the sequencer (valid/ready)
//   ns_*  : toggle req/ack link to one fix_audio_ns engine
interface audio_ns_seq_if #(
    parameter int DW = 16,
    parameter int CW = 36
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ovf;
    logic          out_ready;

    logic          ns_req;
    logic [DW-1:0] ns_rx_data;
    logic [CW-1:0] ns_conf;
    logic          ns_ack;
    logic [DW-1:0] ns_tx_data;
    logic          ns_overflow;

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data, out_ovf,
        input  out_ready,
        output ns_req, ns_rx_data, ns_conf,
        input  ns_ack, ns_tx_data, ns_overflow
    );

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data, out_ovf,
        output out_ready,
        input  ns_req, ns_rx_data, ns_conf,
        output ns_ack, ns_tx_data, ns_overflow
    );
endinterface

// File: rtl/audio_ns_seq.sv
// Sample sequencer: FIFO-buffers samples, issues them to one fix_audio_ns
// engine over toggle req/ack, double-buffers conf, returns results.
// Ports:
//   clk, rstn (async low), enable (clock enable, low = hold all state)
//   io          : audio_ns_seq_if.slave (in/out streams, engine link)
//   conf_wr/conf_wdata : write conf shadow; conf_pend = shadow not applied
//   ovf_cnt     : saturating engine overflow count
//   timeout_err : sticky engine timeout flag
//   clr         : clear ovf_cnt/timeout_err, leave halt
module audio_ns_seq #(
    parameter int          DW       = 16,
    parameter int          CW       = 36,
    parameter int          FIFO_AW  = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [35:0] CONF_RST = 36'h0_4000_0000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    audio_ns_seq_if.slave         io,
    input  logic                  conf_wr,
    input  logic [CW-1:0]         conf_wdata,
    output logic                  conf_pend,
    output logic [7:0]            ovf_cnt,
    output logic                  timeout_err,
    input  logic                  clr
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_ISSUE, S_WAIT, S_OUT, S_HALT
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, push, pop;

    logic [CW-1:0]      shadow, conf_q;
    logic [TW-1:0]      timer;
    logic               ack_d, ack_ev;
    logic               req_q;
    logic [DW-1:0]      rx_q;
    logic               ov_q, oo_q;
    logic [DW-1:0]      od_q;

    logic do_apply, do_issue, do_cap, do_tmo, do_take;

    assign full        = count[FIFO_AW];
    assign empty       = (count == '0);
    assign io.in_ready = !full && enable;
    assign push        = io.in_valid && io.in_ready;
    assign pop         = enable && do_issue;
    assign ack_ev      = io.ns_ack ^ ack_d;

    assign io.ns_req     = req_q;
    assign io.ns_rx_data = rx_q;
    assign io.ns_conf    = conf_q;
    assign io.out_valid  = ov_q;
    assign io.out_data   = od_q;
    assign io.out_ovf    = oo_q;

    always_comb begin
        state_nx = state;
        do_apply = 1'b0;
        do_issue = 1'b0;
        do_cap   = 1'b0;
        do_tmo   = 1'b0;
        do_take  = 1'b0;
        unique case (state)
            S_IDLE: begin
                // pending conf goes first so the next sample sees it
                if (conf_pend)   state_nx = S_APPLY;
                else if (!empty) state_nx = S_ISSUE;
            end
            S_APPLY: begin
                do_apply = 1'b1;
                state_nx = S_IDLE;
            end
            S_ISSUE: begin
                do_issue = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (ack_ev) begin
                    do_cap   = 1'b1;
                    state_nx = S_OUT;
                end else if (timer == TMAX) begin
                    do_tmo   = 1'b1;
                    state_nx = S_HALT;
                end
            end
            S_OUT: begin
                if (io.out_ready) begin
                    do_take  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_HALT: begin
                do_take = io.out_ready;
                if (clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       state <= S_IDLE;
        else if (enable) state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enable) begin
            if (push) begin
                mem[wr_ptr] <= io.in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q       <= 1'b0;
            rx_q        <= '0;
            conf_q      <= CONF_RST;
            shadow      <= CONF_RST;
            conf_pend   <= 1'b0;
            ov_q        <= 1'b0;
            od_q        <= '0;
            oo_q        <= 1'b0;
            ovf_cnt     <= '0;
            timeout_err <= 1'b0;
            ack_d       <= 1'b0;
            timer       <= '0;
        end else if (enable) begin
            // tracking ack every cycle also swallows a late ack while halted
            ack_d <= io.ns_ack;

            // a write landing on the apply cycle stays pending
            if (conf_wr) begin
                shadow    <= conf_wdata;
                conf_pend <= 1'b1;
            end else if (do_apply) begin
                conf_pend <= 1'b0;
            end
            if (do_apply) conf_q <= shadow;

            if (do_issue) begin
                rx_q  <= mem[rd_ptr];
                req_q <= ~req_q;
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + 1'b1;
            end

            if (do_cap) begin
                od_q <= io.ns_tx_data;
                oo_q <= io.ns_overflow;
                ov_q <= 1'b1;
            end else if (do_tmo) begin
                od_q <= '0;
                oo_q <= 1'b1;
                ov_q <= 1'b1;
            end else if (do_take) begin
                ov_q <= 1'b0;
            end

            if (clr)
                ovf_cnt <= '0;
            else if (do_cap && io.ns_overflow && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 1'b1;

            if (do_tmo)   timeout_err <= 1'b1;
            else if (clr) timeout_err <= 1'b0;
        end
    end
endmodule
